// File: rtl/sa_stream_engine.sv
// Weight-stationary systolic matrix engine: y[m] = sum_k x[k]*W[k][m].
// Weights load by command; activation rows stream through a skewed PE grid.
module sa_pe #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              w_load,
  input  logic [DWIDTH-1:0] w_in,
  input  logic [DWIDTH-1:0] a_in,
  input  logic [AWIDTH-1:0] p_in,
  output logic [AWIDTH-1:0] p_out
);
  logic signed [DWIDTH-1:0]   w;
  logic signed [2*DWIDTH-1:0] prod;

  assign prod = $signed(a_in) * w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w     <= '0;
      p_out <= '0;
    end else begin
      if (w_load) w <= w_in;
      if (en)     p_out <= p_in + AWIDTH'(prod);
    end
  end
endmodule

module sa_stream_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2*DWIDTH+$clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [15:0]            cmd_len,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DWIDTH-1:0] w_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DWIDTH-1:0] a_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [COLS*AWIDTH-1:0] o_data,
  output logic                   o_last,
  output logic                   busy,
  output logic                   done
);
  localparam int STAGES = ROWS + COLS - 2;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOADW, S_COMPUTE, S_DRAIN} state_t;

  state_t         state;
  logic [RW-1:0]  wrow;
  logic [15:0]    remain;
  logic           en, a_fire, a_last;

  logic [ROWS-1:0][DWIDTH-1:0]            x;
  logic [ROWS-1:0][COLS-1:0][DWIDTH-1:0]  act;
  logic [ROWS-1:0][COLS-1:0][AWIDTH-1:0]  ps;
  logic [COLS-1:0][AWIDTH-1:0]            col_out;
  logic [STAGES:0]                        vld_pipe, last_pipe;

  // Whole array freezes while a result sits unconsumed at the output.
  assign en        = !(o_valid && !o_ready);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign w_ready   = (state == S_LOADW);
  assign a_ready   = (state == S_COMPUTE) && en;
  assign a_fire    = a_valid && a_ready;
  assign a_last    = (remain == 16'd1);

  always_comb begin
    x = '0;
    for (int k = 0; k < ROWS; k++)
      x[k] = a_fire ? a_data[k*DWIDTH +: DWIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wrow   <= '0;
      remain <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          if (!cmd_op) begin
            state <= S_LOADW;
            wrow  <= '0;
          end else if (cmd_len != 16'd0) begin
            state  <= S_COMPUTE;
            remain <= cmd_len;
          end else begin
            done <= 1'b1;
          end
        end
        S_LOADW: if (w_valid) begin
          wrow <= wrow + 1'b1;
          if (wrow == RW'(ROWS-1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_COMPUTE: if (a_fire) begin
          remain <= remain - 16'd1;
          if (a_last) state <= S_DRAIN;
        end
        S_DRAIN: if (o_valid && o_ready && o_last) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  genvar k, m;
  generate
    for (k = 0; k < ROWS; k++) begin : g_row
      // Row k sees its element k cycles late so partial sums meet it on time.
      if (k == 0) begin : g_noskew
        assign act[0][0] = x[0];
      end else begin : g_skew
        logic [DWIDTH-1:0] sr [k];
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int j = 0; j < k; j++) sr[j] <= '0;
          end else if (en) begin
            sr[0] <= x[k];
            for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
          end
        end
        assign act[k][0] = sr[k-1];
      end

      for (m = 0; m < COLS; m++) begin : g_col
        logic [AWIDTH-1:0] p_in;
        if (m < COLS-1) begin : g_apass
          logic [DWIDTH-1:0] ar;
          always_ff @(posedge clk) begin
            if (!rst_n)  ar <= '0;
            else if (en) ar <= act[k][m];
          end
          assign act[k][m+1] = ar;
        end
        if (k == 0) begin : g_ptop
          assign p_in = '0;
        end else begin : g_pmid
          assign p_in = ps[k-1][m];
        end
        sa_pe #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_pe (
          .clk    (clk),
          .rst_n  (rst_n),
          .en     (en),
          .w_load ((state == S_LOADW) && w_valid && (wrow == RW'(k))),
          .w_in   (w_data[m*DWIDTH +: DWIDTH]),
          .a_in   (act[k][m]),
          .p_in   (p_in),
          .p_out  (ps[k][m])
        );
      end
    end

    for (m = 0; m < COLS; m++) begin : g_deskew
      localparam int D = COLS - 1 - m;
      if (D == 0) begin : g_direct
        assign col_out[m] = ps[ROWS-1][m];
      end else begin : g_delay
        logic [AWIDTH-1:0] dr [D];
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int j = 0; j < D; j++) dr[j] <= '0;
          end else if (en) begin
            dr[0] <= ps[ROWS-1][m];
            for (int j = 1; j < D; j++) dr[j] <= dr[j-1];
          end
        end
        assign col_out[m] = dr[D-1];
      end
    end
  endgenerate

  // Token chain mirrors the datapath depth so valid/last line up with the row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
    end else if (en) begin
      vld_pipe[0]  <= a_fire;
      last_pipe[0] <= a_fire && a_last;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      o_valid <= vld_pipe[STAGES];
      o_last  <= last_pipe[STAGES];
      o_data  <= col_out;
    end
  end
endmodule

// File: doc/sa_stream_engine.md
# sa_stream_engine

Parametrised weight-stationary systolic matrix engine with command-driven weight load and streamed compute. Each activation row x is multiplied by a resident ROWS×COLS weight matrix W, giving y[m] = Σk x[k]·W[k][m]. All data ports use valid/ready handshakes with full output backpressure, and skew/deskew is handled internally. It sits between the coprocessor command decoder and the result writeback path.

## Interface
- ROWS, 4: K dimension; number of PE rows and elements per activation row.
- COLS, 4: N dimension; number of PE columns and elements per weight or result row.
- DWIDTH, 8: signed operand width.
- AWIDTH, 2*DWIDTH+$clog2(ROWS): signed accumulator and result element width.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = LOADW, 1 = COMPUTE.
- cmd_len  in  16  activation rows for COMPUTE; ignored for LOADW.
- w_valid / w_ready  in / out  1 / 1  weight-row handshake.
- w_data  in  COLS*DWIDTH  one weight row; element m at [m*DWIDTH +: DWIDTH].
- a_valid / a_ready  in / out  1 / 1  activation-row handshake.
- a_data  in  ROWS*DWIDTH  one activation row; element k at [k*DWIDTH +: DWIDTH].
- o_valid / o_ready  out / in  1 / 1  result handshake.
- o_data  out  COLS*AWIDTH  result row; element m at [m*AWIDTH +: AWIDTH].
- o_last  out  1  marks the final result row of a COMPUTE command.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, LOADW, COMPUTE, DRAIN.
- IDLE, command accept:
  - A command is accepted on cmd_valid && cmd_ready.
  - op 0 → LOADW.
  - op 1 with len > 0 → COMPUTE.
  - op 1 with len = 0 → stay in IDLE, done pulses the next cycle, no output.
- LOADW:
  - w_ready = 1; a_ready = 0.
  - Beat r (0..ROWS-1) writes W[r][*].
  - After beat ROWS-1 → IDLE, with done on the cycle after that beat.
  - W persists until the next LOADW or reset.
- COMPUTE:
  - a_ready = en, where en = !(o_valid && !o_ready).
  - An accepted row enters the skew stage; element k is delayed k cycles before reaching PE row k.
  - Partial sums flow down the columns. Column m output is deskewed by (COLS-1-m) cycles so that a result row emerges aligned.
  - After len rows are accepted → DRAIN.
- DRAIN:
  - a_ready = 0; bubbles shift in.
  - When the result row tagged last completes its handshake → IDLE, done pulses the next cycle.
- Pipeline stall:
  - All skew registers, PEs, deskew registers and the valid/last token chain advance only when en = 1.
  - The o_data, o_valid and o_last registers hold while stalled.
- Arithmetic: signed DWIDTH × DWIDTH products, summed in AWIDTH two's complement. Sums wrap modulo 2^AWIDTH; there is no saturation.
- w_ready is 0 outside LOADW. Weights never change during COMPUTE or DRAIN.
- cmd_valid while busy is ignored and is not queued.

## Timing
- Reset values:
  - State IDLE.
  - cmd_ready = 1; w_ready, a_ready, o_valid, o_last, busy, done = 0.
  - o_data = 0, all W = 0, all pipeline registers and tokens = 0.
- Reset mid-command aborts it immediately. No done pulse is issued, and in-flight results are discarded.
- Latency: a row accepted at cycle t gives o_valid at t+ROWS+COLS, with no stalls. Each stall cycle adds 1.
- Throughput: 1 row/cycle with a_valid and o_ready held high. There are no gaps between back-to-back rows.
- Ordering: outputs appear in acceptance order. Exactly len result rows per COMPUTE.
- busy rises the cycle after command accept. It falls the same cycle done is asserted.
- A new command is acceptable on the cycle done is high.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles → cmd_ready = 1, all other outputs 0, o_data = 0; then COMPUTE len = 1 with a_data = {4,3,2,1} → o_data all 0 (zero weights).
- Identity, ROWS = COLS = 4: LOADW identity, then COMPUTE len = 1 with {4,3,2,1} → o_data {4,3,2,1}, o_valid at accept+8, o_last = 1, done the next cycle.
- Signed extremes: W all -1; rows {127,127,127,127} and {-128,-128,-128,-128} → results -508 and +512 per column, back-to-back cycles.
- Backpressure: COMPUTE len = 8 streaming, o_ready low for 3 cycles mid-stream → 8 correct in-order rows, a_ready low during the stall, o_last only on the 8th row.
- Boundaries:
  - COMPUTE len = 0 → done 1 cycle later with no o_valid.
  - cmd_valid during COMPUTE → ignored and not executed.
  - w_valid during COMPUTE → weights unchanged.
- Abort: assert rst_n = 0 mid-COMPUTE (3 of 6 rows accepted) → next cycle IDLE, o_valid = 0, no done, W cleared.
